spin_sequencer: RTL and testbench

Round controller for the four-reel slot display. It accepts the spin button and charges a credit. It then runs all reels, stops them one at a time in a staggered order, latches the scorer result, pays out credits, and holds the final display. It sits between the user inputs and the reel, rng and scorer datapath, replacing the ad-hoc clk_2s/clk_5s timing and multi-edge always blocks with one clocked FSM.

---
 rtl/spin_sequencer_pkg.sv | 38 +++
 rtl/spin_sequencer_if.sv | 27 ++
 rtl/sync_edge.sv | 24 ++
 rtl/spin_sequencer.sv | 153 +++++++++++++++
 tb/tb_spin_sequencer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/spin_sequencer_pkg.sv
// Shared types and constants for the slot-machine round controller.
// The saturating credit add lives here so every credit path uses the same arithmetic.
package spin_sequencer_pkg;

    localparam int REELS    = 4;
    localparam int CREDIT_W = 8;
    localparam int SCORE_W  = 4;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(255);

    typedef enum logic [2:0] {
        IDLE,
        SPIN,
        STOP,
        SCORE,
        SHOW
    } state_t;

    // Everything the sequencer drives, kept in one register so reset and hold are uniform.
    typedef struct packed {
        logic [REELS-1:0]    reel_run;
        logic [REELS-1:0]    reel_stop;
        logic                show_final;
        logic [SCORE_W-1:0]  score;
        logic [CREDIT_W-1:0] credits;
        logic                busy;
        logic                round_done;
        logic                no_credit;
    } outs_t;

    function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                    input logic [SCORE_W-1:0]  b);
        logic [CREDIT_W:0] sum;
        sum = {1'b0, a} + {{(CREDIT_W + 1 - SCORE_W){1'b0}}, b};
        return (sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : sum[CREDIT_W-1:0];
    endfunction

endpackage

// File: rtl/spin_sequencer_if.sv
// User-input / reel-datapath bundle of the round controller.
// The sequencer takes the slave side; the board (or bench) takes the master side.
interface spin_sequencer_if;
    import spin_sequencer_pkg::*;

    logic                spin;
    logic [SCORE_W-1:0]  score_in;
    logic [REELS-1:0]    reel_run;
    logic [REELS-1:0]    reel_stop;
    logic                show_final;
    logic [SCORE_W-1:0]  score;
    logic [CREDIT_W-1:0] credits;
    logic                busy;
    logic                round_done;
    logic                no_credit;

    modport master (
        output spin, score_in,
        input  reel_run, reel_stop, show_final, score, credits, busy, round_done, no_credit
    );

    modport slave (
        input  spin, score_in,
        output reel_run, reel_stop, show_final, score, credits, busy, round_done, no_credit
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a rising-edge detector.
// rise is high for exactly one clk cycle per low-to-high transition of level.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    // taps [0],[1] form the synchroniser; [2] remembers the previous synchronised level
    logic [2:0] taps;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else begin
            taps <= {taps[1:0], level};
        end
    end

    assign rise = taps[1] & ~taps[2];

endmodule

// File: rtl/spin_sequencer.sv
// Round controller: charge a credit, run all reels, stop them one by one,
// latch the scorer result, pay out, then hold the final display.
module spin_sequencer
    import spin_sequencer_pkg::*;
#(
    parameter int SPIN_CYCLES = 1400,
    parameter int STOP_GAP    = 350,
    parameter int SCORE_LAT   = 2,
    parameter int SHOW_CYCLES = 3500,
    parameter int CREDIT_INIT = 10,
    parameter int SPIN_COST   = 1
) (
    input logic             clk,
    input logic             rst_n,
    spin_sequencer_if.slave bus
);

    localparam int MAX_AB = (SPIN_CYCLES > STOP_GAP) ? SPIN_CYCLES : STOP_GAP;
    localparam int MAX_CD = (SCORE_LAT > SHOW_CYCLES) ? SCORE_LAT : SHOW_CYCLES;
    localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_T + 1);
    localparam int IDX_W  = $clog2(REELS);

    // Counters are loaded with N-1 and expire at zero, giving exactly N cycles per phase.
    localparam logic [CNT_W-1:0] SPIN_LOAD  = CNT_W'(SPIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(STOP_GAP - 1);
    localparam logic [CNT_W-1:0] SCORE_LOAD = CNT_W'(SCORE_LAT - 1);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_CYCLES - 1);

    localparam logic [IDX_W-1:0]    LAST_REEL = IDX_W'(REELS - 1);
    localparam logic [CREDIT_W-1:0] COST      = CREDIT_W'(SPIN_COST);

    localparam bit PARAMS_OK = (SPIN_CYCLES >= 1) && (STOP_GAP >= 1) &&
                               (SCORE_LAT >= 1) && (SHOW_CYCLES >= 1);

    localparam outs_t RESET_OUTS = '{
        reel_run:   '0,
        reel_stop:  '0,
        show_final: 1'b0,
        score:      '0,
        credits:    CREDIT_W'(CREDIT_INIT),
        busy:       1'b0,
        round_done: 1'b0,
        no_credit:  1'b0
    };

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] reel_idx, reel_idx_n;
    outs_t            r, r_n;
    logic             spin_rise;

    sync_edge u_spin_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .level (bus.spin),
        .rise  (spin_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            reel_idx <= '0;
            r        <= RESET_OUTS;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            reel_idx <= reel_idx_n;
            r        <= r_n;
        end
    end

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        reel_idx_n   = reel_idx;
        r_n          = r;
        r_n.reel_stop  = '0;
        r_n.round_done = 1'b0;
        r_n.no_credit  = 1'b0;

        unique case (state)
            IDLE: begin
                if (spin_rise) begin
                    if (r.credits >= COST) begin
                        state_n      = SPIN;
                        cnt_n        = SPIN_LOAD;
                        reel_idx_n   = '0;
                        r_n.reel_run = '1;
                        r_n.credits  = r.credits - COST;
                        r_n.score    = '0;
                    end else begin
                        r_n.no_credit = 1'b1;
                    end
                end
            end
            // SPIN expiry freezes reel 0; STOP then freezes the rest one gap apart.
            SPIN, STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    r_n.reel_stop[reel_idx] = 1'b1;
                    r_n.reel_run[reel_idx]  = 1'b0;
                    if (reel_idx == LAST_REEL) begin
                        state_n = SCORE;
                        cnt_n   = SCORE_LOAD;
                    end else begin
                        state_n    = STOP;
                        cnt_n      = GAP_LOAD;
                        reel_idx_n = reel_idx + 1'b1;
                    end
                end
            end
            SCORE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n        = SHOW;
                    cnt_n          = SHOW_LOAD;
                    r_n.score      = bus.score_in;
                    r_n.credits    = sat_add(r.credits, bus.score_in);
                    r_n.show_final = 1'b1;
                end
            end
            SHOW: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n        = IDLE;
                    r_n.show_final = 1'b0;
                    r_n.round_done = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        r_n.busy = (state_n != IDLE);
    end

    assign bus.reel_run   = r.reel_run;
    assign bus.reel_stop  = r.reel_stop;
    assign bus.show_final = r.show_final;
    assign bus.score      = r.score;
    assign bus.credits    = r.credits;
    assign bus.busy       = r.busy;
    assign bus.round_done = r.round_done;
    assign bus.no_credit  = r.no_credit;

    a_params_nonzero: assert property (@(posedge clk) PARAMS_OK);

endmodule

// File: tb/tb_spin_sequencer.sv
// Scoreboard bench for spin_sequencer: stimulus queues hand-timed output events,
// a negedge monitor pops and compares one entry each time the DUT presents an event.
module tb_spin_sequencer;
    import spin_sequencer_pkg::*;

    localparam int SPIN_CYCLES = 8;
    localparam int STOP_GAP    = 4;
    localparam int SCORE_LAT   = 2;
    localparam int SHOW_CYCLES = 6;
    localparam int CREDIT_INIT = 3;
    localparam int SYNC_LAT    = 3;  // press edge to SPIN entry: two sync flops plus FSM edge

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  run;
        logic [3:0]  stop;
        logic        show;
        logic        busy;
        logic        done;
        logic        noc;
        logic [3:0]  score;
        logic [7:0]  credits;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spin_sequencer_if bus ();

    spin_sequencer #(
        .SPIN_CYCLES (SPIN_CYCLES),
        .STOP_GAP    (STOP_GAP),
        .SCORE_LAT   (SCORE_LAT),
        .SHOW_CYCLES (SHOW_CYCLES),
        .CREDIT_INIT (CREDIT_INIT),
        .SPIN_COST   (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ev_t   exp_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    credits_m   = CREDIT_INIT;
    int    round_no    = 0;
    logic  busy_q      = 1'b0;
    logic  show_q      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [23:0] outs();
        return {bus.reel_run, bus.reel_stop, bus.show_final, bus.busy,
                bus.round_done, bus.no_credit, bus.score, bus.credits};
    endfunction

    task automatic compare_event();
        ev_t   got;
        ev_t   want;
        string n;
        got = {32'(cyc), outs()};
        if (exp_q.size() == 0) begin
            check("unexpected_event", 64'(got), 64'(0));
        end else begin
            want = exp_q.pop_front();
            n    = name_q.pop_front();
            check(n, 64'(got), 64'(want));
        end
    endtask

    // Monitor: an event is a round start, any reel stop, show rising, round_done or no_credit.
    always @(negedge clk) begin
        if (rst_n && ((bus.busy && !busy_q) || (bus.reel_stop != 4'b0000) ||
                      (bus.show_final && !show_q) || bus.round_done || bus.no_credit))
            compare_event();
        busy_q <= bus.busy;
        show_q <= bus.show_final;
    end

    task automatic push(input string name, input int c, input logic [3:0] run,
                        input logic [3:0] stop, input logic show, input logic busy,
                        input logic done, input logic noc, input logic [3:0] score,
                        input logic [7:0] credits);
        ev_t e;
        e.cyc = 32'(c);  e.run = run;   e.stop = stop;   e.show = show;
        e.busy = busy;   e.done = done; e.noc = noc;     e.score = score;
        e.credits = credits;
        exp_q.push_back(e);
        name_q.push_back($sformatf("r%0d_%s", round_no, name));
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One round: press at p, SPIN entry at p+3, stops at +8/+12/+16/+20, show +22, done +28.
    task automatic run_round(input logic [3:0] s, input int hold, input bit repress, input bit abort);
        int p, base, sum;
        logic [7:0] charged, paid;
        @(posedge clk);
        #1;
        round_no++;
        p       = cyc;
        base    = p + SYNC_LAT;
        charged = 8'(credits_m - 1);
        sum     = credits_m - 1 + int'(s);
        paid    = (sum > 255) ? 8'd255 : 8'(sum);
        push("start", base,      4'b1111, 4'b0000, 0, 1, 0, 0, 4'd0, charged);
        push("stop0", base + 8,  4'b1110, 4'b0001, 0, 1, 0, 0, 4'd0, charged);
        push("stop1", base + 12, 4'b1100, 4'b0010, 0, 1, 0, 0, 4'd0, charged);
        if (!abort) begin
            push("stop2", base + 16, 4'b1000, 4'b0100, 0, 1, 0, 0, 4'd0, charged);
            push("stop3", base + 20, 4'b0000, 4'b1000, 0, 1, 0, 0, 4'd0, charged);
            push("show",  base + 22, 4'b0000, 4'b0000, 1, 1, 0, 0, s, paid);
            push("done",  base + 28, 4'b0000, 4'b0000, 0, 0, 1, 0, s, paid);
        end
        bus.score_in = s;
        bus.spin     = 1'b1;
        wait_cyc(p + hold);
        bus.spin = 1'b0;
        if (repress) begin
            wait_cyc(base + 13);  bus.spin = 1'b1;   // lands in STOP
            wait_cyc(base + 15);  bus.spin = 1'b0;
            wait_cyc(base + 22);  bus.spin = 1'b1;   // lands in SHOW
            wait_cyc(base + 24);  bus.spin = 1'b0;
        end
        if (abort) begin
            wait_cyc(base + 14);
        end else begin
            credits_m = int'(paid);
            wait_cyc((base + 30 > p + hold + 4) ? base + 30 : p + hold + 4);
        end
    endtask

    initial begin
        int p;
        bus.spin     = 1'b0;
        bus.score_in = 4'd0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 64'(outs()), 64'(24'h000003));
        rst_n = 1'b1;
        wait_cyc(cyc + 2);

        run_round(4'd5, 1, 1'b0, 1'b0);    // nominal: 3 -> 2 -> 7
        run_round(4'd1, 1, 1'b1, 1'b0);    // re-press in STOP and SHOW: 7 -> 6 -> 7
        run_round(4'd1, 100, 1'b0, 1'b0);  // held button: one round only, 7 -> 7
        for (int i = 0; i < 27; i++)
            run_round(4'd10, 1, 1'b0, 1'b0);  // 7 + 27*9 = 250
        check("credits_250", 64'(bus.credits), 64'(8'd250));
        run_round(4'd10, 1, 1'b0, 1'b0);   // 250 - 1 + 10 saturates
        check("credits_sat", 64'(bus.credits), 64'(8'd255));

        run_round(4'd0, 1, 1'b0, 1'b1);    // abandoned two cycles after reel_stop[1]
        rst_n = 1'b0;
        #1;
        check("mid_reset_async", 64'(outs()), 64'(24'h000003));
        wait_cyc(cyc + 2);
        rst_n     = 1'b1;
        credits_m = CREDIT_INIT;

        run_round(4'd0, 1, 1'b0, 1'b0);    // clean round after reset: 3 -> 2
        run_round(4'd0, 1, 1'b0, 1'b0);    // 2 -> 1
        run_round(4'd0, 1, 1'b0, 1'b0);    // 1 -> 0

        @(posedge clk);
        #1;
        round_no++;
        p = cyc;
        push("no_credit", p + SYNC_LAT, 4'b0000, 4'b0000, 0, 0, 0, 1, 4'd0, 8'd0);
        bus.spin = 1'b1;
        wait_cyc(p + 1);
        bus.spin = 1'b0;
        wait_cyc(p + 15);
        check("idle_after_reject", 64'(outs()), 64'(24'h000000));

        wait_cyc(cyc + 4);
        check("pending_events", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached with %0d events pending, want 0", exp_q.size());
        $fatal(1, "watchdog");
    end

endmodule
